ibex_rf_wb_arbiter: RTL and testbench
=====================================

# ibex_rf_wb_arbiter

Write-back arbiter that owns the single register-file write port (waddr/wdata/we) on behalf of the two result producers: the EX stage (ALU/MULT, cannot stall) and the LSU (load data, valid/ready). LSU results are buffered in a small in-order FIFO and drained into cycles where EX is not writing. The block drives a registered write-back stage into the register file. It also reports read-after-write hazards on the two register-file read addresses so the ID stage can stall.

## Interface
- DataWidth, 32, width of register data
- RV32E, 0, when 1 only x0..x15 exist; writes with waddr[4]=1 are dropped
- FifoDepth, 2, LSU buffer entries (power of 2, ≥2)

- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- ex_we_i  input  1  EX result write request (always accepted)
- ex_waddr_i  input  5  EX destination register
- ex_wdata_i  input  DataWidth  EX result
- lsu_valid_i  input  1  LSU load result valid
- lsu_waddr_i  input  5  LSU destination register
- lsu_wdata_i  input  DataWidth  LSU load data
- lsu_ready_o  output  1  FIFO can accept; transfer when valid&ready
- rf_we_o  output  1  register-file write enable (registered)
- rf_waddr_o  output  5  register-file write address (registered)
- rf_wdata_o  output  DataWidth  register-file write data (registered)
- raddr_a_i  input  5  ID read address A
- raddr_b_i  input  5  ID read address B
- hazard_a_o  output  1  raddr_a_i has a write pending in this block
- hazard_b_o  output  1  raddr_b_i has a write pending in this block

## Operation
- Reset: FIFO empty (wr/rd pointers 0, all entry valids 0), rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0; lsu_ready_o=1 after reset; hazard outputs 0.
- Drop rule: any write to x0, or with RV32E=1 to waddr[4]=1, is discarded at input (EX: no stage update; LSU: handshake completes, nothing enqueued).
- LSU enqueue: lsu_valid_i & lsu_ready_o writes {waddr, wdata, live=1} at wr pointer; pointers are log2(FifoDepth)+1 bits, wrap modulo 2*FifoDepth; full = MSBs differ, low bits equal.
- lsu_ready_o = !full (combinational from state only, not from lsu_valid_i).
- Stage selection each cycle, priority: (1) ex_we_i (non-dropped) loads EX into stage; (2) else FIFO non-empty: pop head, load stage with rf_we=head.live; (3) else rf_we_o<=0 (addr/data hold).
- Pop and enqueue in the same cycle are legal when full: no, ready is from state; when full, no enqueue that cycle even if a pop occurs.
- WAW ordering: an accepted EX write clears live of every FIFO entry with equal waddr (entries are older). A dead entry still pops in turn, producing rf_we_o=0 that cycle.
- Same-cycle EX write and LSU handshake to the same waddr: LSU result is older; it is enqueued with live=0.
- Hazard: hazard_x_o = raddr_x_i≠0 & (match any live FIFO entry, or match rf_waddr_o while rf_we_o=1, or match ex_waddr_i while ex_we_i=1 not dropped). Combinational.

## Timing
- EX write: ex_we_i in cycle N -> rf_we_o high in N+1; fixed 1-cycle latency.
- LSU write with empty FIFO and no EX write in N+1: handshake in N -> rf_we_o in N+2 (enqueue N, pop N+1).
- LSU entries drain strictly in order, one per EX-idle cycle; a continuous EX stream starves the FIFO (by design; core pipeline guarantees gaps).
- Reset mid-operation discards all buffered LSU entries and the stage; no partial write is emitted after rst_ni deasserts.

## Test plan
- Reset then ex_we_i=1, waddr=5, wdata=0xA5A5_0001 at N -> rf_we_o=1, waddr 5, data 0xA5A5_0001 at N+1; hazard_a_o=1 for raddr_a=5 at N and N+1, 0 at N+2.
- LSU x7=0x1234 accepted while EX writes x3, x4 on next two cycles -> rf writes x3, x4, then x7 in order; x7 hazard held until its write cycle.
- Fill FIFO (2 LSU writes during EX burst) -> lsu_ready_o=0; third lsu_valid_i held; after one EX-idle pop, ready returns 1 next cycle.
- LSU x9=0x1 buffered, then EX x9=0x2 -> rf writes x9=0x2; buffered entry pops with rf_we_o=0; final x9 value 0x2.
- Same cycle EX x10=0xB and LSU x10=0xC -> only 0xB written; LSU handshake completes.
- Writes to x0 from both sources, and RV32E=1 write to x20 -> rf_we_o never asserted, no hazard; async reset asserted with 2 entries buffered -> no writes after release.

Source files
------------

// File: rtl/ibex_rf_wb_arbiter_if.sv
// Bus bundle for the write-back arbiter: EX and LSU result inputs, the
// registered register-file write port, and the ID-stage hazard query.
interface ibex_rf_wb_arbiter_if #(
  parameter int DataWidth = 32
);
  logic                 ex_we_i;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 lsu_valid_i;
  logic [4:0]           lsu_waddr_i;
  logic [DataWidth-1:0] lsu_wdata_i;
  logic                 lsu_ready_o;
  logic                 rf_we_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic [4:0]           raddr_a_i;
  logic [4:0]           raddr_b_i;
  logic                 hazard_a_o;
  logic                 hazard_b_o;

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output lsu_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o,
    input  raddr_a_i, raddr_b_i,
    output hazard_a_o, hazard_b_o
  );

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  lsu_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o,
    output raddr_a_i, raddr_b_i,
    input  hazard_a_o, hazard_b_o
  );
endinterface

// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file write-back arbiter: EX writes win, LSU loads are buffered in
// an in-order FIFO and drained into EX-idle cycles; reports RAW hazards to ID.
module ibex_rf_wb_arbiter #(
  parameter int DataWidth = 32,
  parameter bit RV32E     = 1'b0,
  parameter int FifoDepth = 2
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  ibex_rf_wb_arbiter_if.slave    bus
);
  localparam int PW = $clog2(FifoDepth);

  // LSU handshake: a load transfers on any cycle where lsu_valid_i and
  // lsu_ready_o are both high; ready depends only on FIFO state.
  logic [PW:0]          r_wr_ptr, r_rd_ptr;
  logic [4:0]           r_addr [FifoDepth];
  logic [DataWidth-1:0] r_data [FifoDepth];
  logic [FifoDepth-1:0] r_live;
  logic                 r_we;
  logic [4:0]           r_waddr;
  logic [DataWidth-1:0] r_wdata;

  logic          w_empty, w_full, w_ex_drop, w_lsu_drop, w_ex_we, w_enq, w_pop;
  logic          w_enq_live, w_hit_a, w_hit_b;
  logic [PW-1:0] w_wr_idx, w_rd_idx;

  assign w_wr_idx   = r_wr_ptr[PW-1:0];
  assign w_rd_idx   = r_rd_ptr[PW-1:0];
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (w_wr_idx == w_rd_idx);
  assign w_ex_drop  = (bus.ex_waddr_i == 5'd0) || (RV32E && bus.ex_waddr_i[4]);
  assign w_lsu_drop = (bus.lsu_waddr_i == 5'd0) || (RV32E && bus.lsu_waddr_i[4]);
  assign w_ex_we    = bus.ex_we_i && !w_ex_drop;
  assign w_enq      = bus.lsu_valid_i && !w_full && !w_lsu_drop;
  assign w_pop      = !w_ex_we && !w_empty;
  // A load arriving alongside an EX write to the same register is the older result.
  assign w_enq_live = !(w_ex_we && (bus.ex_waddr_i == bus.lsu_waddr_i));

  assign bus.lsu_ready_o = !w_full;
  assign bus.rf_we_o     = r_we;
  assign bus.rf_waddr_o  = r_waddr;
  assign bus.rf_wdata_o  = r_wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_live   <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // Buffered loads are older than an accepted EX write to the same register.
      for (int i = 0; i < FifoDepth; i++) begin
        if (w_ex_we && r_live[i] && (r_addr[i] == bus.ex_waddr_i)) r_live[i] <= 1'b0;
      end
      if (w_ex_we) begin
        r_we    <= 1'b1;
        r_waddr <= bus.ex_waddr_i;
        r_wdata <= bus.ex_wdata_i;
      end else if (w_pop) begin
        r_we             <= r_live[w_rd_idx];
        r_waddr          <= r_addr[w_rd_idx];
        r_wdata          <= r_data[w_rd_idx];
        r_live[w_rd_idx] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + 1'b1;
      end else begin
        r_we <= 1'b0;
      end
      if (w_enq) begin
        r_addr[w_wr_idx] <= bus.lsu_waddr_i;
        r_data[w_wr_idx] <= bus.lsu_wdata_i;
        r_live[w_wr_idx] <= w_enq_live;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    for (int i = 0; i < FifoDepth; i++) begin
      if (r_live[i] && (r_addr[i] == bus.raddr_a_i)) w_hit_a = 1'b1;
      if (r_live[i] && (r_addr[i] == bus.raddr_b_i)) w_hit_b = 1'b1;
    end
    if (r_we && (r_waddr == bus.raddr_a_i)) w_hit_a = 1'b1;
    if (r_we && (r_waddr == bus.raddr_b_i)) w_hit_b = 1'b1;
    if (w_ex_we && (bus.ex_waddr_i == bus.raddr_a_i)) w_hit_a = 1'b1;
    if (w_ex_we && (bus.ex_waddr_i == bus.raddr_b_i)) w_hit_b = 1'b1;
  end

  assign bus.hazard_a_o = w_hit_a && (bus.raddr_a_i != 5'd0);
  assign bus.hazard_b_o = w_hit_b && (bus.raddr_b_i != 5'd0);
endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Self-checking bench for ibex_rf_wb_arbiter: directed scenarios plus random
// traffic, with a queue model of the LSU buffer feeding an expected-write queue.
module tb_ibex_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int DEPTH = 2;
  localparam int W = 5 + DW;

  typedef struct packed { logic [4:0] a; logic [DW-1:0] d; logic live; } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_rf_wb_arbiter_if #(.DataWidth(DW)) bus ();
  ibex_rf_wb_arbiter_if #(.DataWidth(DW)) bus_e ();

  ibex_rf_wb_arbiter #(.DataWidth(DW), .RV32E(1'b0), .FifoDepth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus));
  ibex_rf_wb_arbiter #(.DataWidth(DW), .RV32E(1'b1), .FifoDepth(DEPTH)) dut_e (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_e));

  int n_total = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  ent_t mq[$];
  logic m_we = 1'b0;
  logic [4:0] m_waddr = '0;
  logic [DW-1:0] shadow [32];

  task automatic set_in(input logic ew, input logic [4:0] ea, input logic [DW-1:0] ed,
                        input logic lv, input logic [4:0] la, input logic [DW-1:0] ld);
    bus.ex_we_i = ew; bus.ex_waddr_i = ea; bus.ex_wdata_i = ed;
    bus.lsu_valid_i = lv; bus.lsu_waddr_i = la; bus.lsu_wdata_i = ld;
  endtask

  function automatic logic model_hazard(input logic [4:0] ra, input logic ex_acc);
    logic h;
    h = m_we && (m_waddr == ra);
    if (ex_acc && (bus.ex_waddr_i == ra)) h = 1'b1;
    foreach (mq[i]) if (mq[i].live && (mq[i].a == ra)) h = 1'b1;
    return h && (ra != 5'd0);
  endfunction

  // Advance one clock: check combinational outputs against the model, update the
  // model, then compare any register-file write with the expected queue.
  task automatic tick();
    ent_t e;
    logic rdy, ex_acc, enq, eh_a, eh_b;
    logic [W-1:0] got, want;
    #1;
    rdy = (mq.size() < DEPTH);
    ex_acc = bus.ex_we_i && (bus.ex_waddr_i != 5'd0);
    eh_a = model_hazard(bus.raddr_a_i, ex_acc);
    eh_b = model_hazard(bus.raddr_b_i, ex_acc);
    n_total++;
    if (bus.lsu_ready_o !== rdy) begin
      n_bad++; $display("FAIL lsu_ready: got %b want %b", bus.lsu_ready_o, rdy);
    end
    n_total++;
    if (bus.hazard_a_o !== eh_a) begin
      n_bad++; $display("FAIL hazard_a x%0d: got %b want %b", bus.raddr_a_i, bus.hazard_a_o, eh_a);
    end
    n_total++;
    if (bus.hazard_b_o !== eh_b) begin
      n_bad++; $display("FAIL hazard_b x%0d: got %b want %b", bus.raddr_b_i, bus.hazard_b_o, eh_b);
    end
    enq = bus.lsu_valid_i && rdy && (bus.lsu_waddr_i != 5'd0);
    if (ex_acc) begin
      foreach (mq[i]) if (mq[i].a == bus.ex_waddr_i) mq[i].live = 1'b0;
      exp_q.push_back({bus.ex_waddr_i, bus.ex_wdata_i});
      m_we = 1'b1; m_waddr = bus.ex_waddr_i;
    end else if (mq.size() != 0) begin
      e = mq.pop_front();
      m_we = e.live; m_waddr = e.a;
      if (e.live) exp_q.push_back({e.a, e.d});
    end else begin
      m_we = 1'b0;
    end
    if (enq) begin
      e.a = bus.lsu_waddr_i; e.d = bus.lsu_wdata_i;
      e.live = !(ex_acc && (bus.ex_waddr_i == bus.lsu_waddr_i));
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (bus.rf_we_o === 1'b1) begin
      got = {bus.rf_waddr_o, bus.rf_wdata_o};
      shadow[bus.rf_waddr_o] = bus.rf_wdata_o;
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL extra_write: got x%0d=%h want no write", bus.rf_waddr_o, bus.rf_wdata_o);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++; $display("FAIL rf_write: got x%0d=%h want x%0d=%h",
                            got[W-1:DW], got[DW-1:0], want[W-1:DW], want[DW-1:0]);
        end
      end
    end
  endtask

  task automatic drain();
    set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    repeat (DEPTH + 2) tick();
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL drain: got %0d pending writes want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    bus.raddr_a_i = 5'd5; bus.raddr_b_i = 5'd0;
    bus_e.ex_we_i = 1'b0; bus_e.ex_waddr_i = '0; bus_e.ex_wdata_i = '0;
    bus_e.lsu_valid_i = 1'b0; bus_e.lsu_waddr_i = '0; bus_e.lsu_wdata_i = '0;
    bus_e.raddr_a_i = '0; bus_e.raddr_b_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== '0) begin
      n_bad++; $display("FAIL reset_rf: got we=%b x%0d=%h want all 0", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o);
    end
    n_total++;
    if ({bus.lsu_ready_o, bus.hazard_a_o, bus.hazard_b_o} !== 3'b100) begin
      n_bad++; $display("FAIL reset_flags: got ready/ha/hb=%b%b%b want 100", bus.lsu_ready_o, bus.hazard_a_o, bus.hazard_b_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ex_write();
    bus.raddr_a_i = 5'd5; bus.raddr_b_i = 5'd6;
    set_in(1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd0, '0);
    #1;
    n_total++;
    if (bus.hazard_a_o !== 1'b1) begin n_bad++; $display("FAIL ex_haz_n: got %b want 1", bus.hazard_a_o); end
    tick();
    set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1;
    n_total++;
    if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 5'd5, 32'hA5A5_0001}) begin
      n_bad++; $display("FAIL ex_write: got we=%b x%0d=%h want 1 x5=a5a50001", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o);
    end
    n_total++;
    if (bus.hazard_a_o !== 1'b1) begin n_bad++; $display("FAIL ex_haz_n1: got %b want 1", bus.hazard_a_o); end
    tick();
    n_total++;
    if ({bus.rf_we_o, bus.hazard_a_o} !== 2'b00) begin
      n_bad++; $display("FAIL ex_idle_n2: got we/haz=%b%b want 00", bus.rf_we_o, bus.hazard_a_o);
    end
    drain();
  endtask

  task automatic test_lsu_order();
    bus.raddr_a_i = 5'd7; bus.raddr_b_i = 5'd3;
    set_in(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h0000_1234); tick();
    set_in(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, '0); tick();
    set_in(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, '0); tick();
    n_total++;
    if (bus.hazard_a_o !== 1'b1) begin n_bad++; $display("FAIL lsu_haz_held: got %b want 1", bus.hazard_a_o); end
    set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0); tick();
    n_total++;
    if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.hazard_a_o} !== {1'b1, 5'd7, 32'h1234, 1'b1}) begin
      n_bad++; $display("FAIL lsu_x7: got we=%b x%0d=%h haz=%b want 1 x7=1234 haz 1",
                        bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.hazard_a_o);
    end
    tick();
    n_total++;
    if (bus.hazard_a_o !== 1'b0) begin n_bad++; $display("FAIL lsu_haz_clear: got %b want 0", bus.hazard_a_o); end
    drain();
  endtask

  task automatic test_fifo_full();
    bus.raddr_a_i = 5'd11; bus.raddr_b_i = 5'd13;
    set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB1); tick();
    set_in(1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'hB2); tick();
    n_total++;
    if (bus.lsu_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", bus.lsu_ready_o); end
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd13, 32'hB3); tick();
    set_in(1'b0, 5'd0, '0, 1'b1, 5'd13, 32'hB3); tick();
    n_total++;
    if (bus.lsu_ready_o !== 1'b1) begin n_bad++; $display("FAIL full_ready_back: got %b want 1", bus.lsu_ready_o); end
    tick();
    drain();
  endtask

  task automatic test_waw();
    bus.raddr_a_i = 5'd9; bus.raddr_b_i = 5'd0;
    set_in(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h1); tick();
    set_in(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, '0); tick();
    set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1;
    n_total++;
    if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 5'd9, 32'h2}) begin
      n_bad++; $display("FAIL waw_ex: got we=%b x%0d=%h want 1 x9=2", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o);
    end
    tick();
    n_total++;
    if (bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL waw_dead_pop: got %b want 0", bus.rf_we_o); end
    drain();
    n_total++;
    if (shadow[9] !== 32'h2) begin n_bad++; $display("FAIL waw_final: got %h want 2", shadow[9]); end
  endtask

  task automatic test_same_cycle();
    bus.raddr_a_i = 5'd10; bus.raddr_b_i = 5'd0;
    set_in(1'b1, 5'd10, 32'hB, 1'b1, 5'd10, 32'hC); tick();
    set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0); tick();
    n_total++;
    if (bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL same_dead_pop: got %b want 0", bus.rf_we_o); end
    drain();
    n_total++;
    if (shadow[10] !== 32'hB) begin n_bad++; $display("FAIL same_final: got %h want b", shadow[10]); end
  endtask

  task automatic test_drop();
    bus.raddr_a_i = 5'd0; bus.raddr_b_i = 5'd0;
    bus_e.raddr_a_i = 5'd20;
    bus_e.ex_we_i = 1'b1; bus_e.ex_waddr_i = 5'd20; bus_e.ex_wdata_i = 32'hDEAD;
    bus_e.lsu_valid_i = 1'b1; bus_e.lsu_waddr_i = 5'd20; bus_e.lsu_wdata_i = 32'hBEEF;
    set_in(1'b1, 5'd0, 32'hF0, 1'b1, 5'd0, 32'hF1);
    #1;
    n_total++;
    if ({bus_e.hazard_a_o, bus_e.lsu_ready_o} !== 2'b01) begin
      n_bad++; $display("FAIL e_drop_comb: got haz/ready=%b%b want 01", bus_e.hazard_a_o, bus_e.lsu_ready_o);
    end
    tick();
    bus_e.ex_we_i = 1'b0; bus_e.lsu_valid_i = 1'b0;
    set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({bus.rf_we_o, bus_e.rf_we_o, bus_e.hazard_a_o} !== 3'b000) begin
        n_bad++; $display("FAIL drop_we: got we/we_e/haz_e=%b%b%b want 000", bus.rf_we_o, bus_e.rf_we_o, bus_e.hazard_a_o);
      end
      tick();
    end
    bus_e.ex_we_i = 1'b1; bus_e.ex_waddr_i = 5'd5;
    @(posedge clk);
    #1;
    bus_e.ex_we_i = 1'b0;
    n_total++;
    if ({bus_e.rf_we_o, bus_e.rf_waddr_o} !== {1'b1, 5'd5}) begin
      n_bad++; $display("FAIL e_low_write: got we=%b x%0d want 1 x5", bus_e.rf_we_o, bus_e.rf_waddr_o);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.raddr_a_i = 5'd7; bus.raddr_b_i = 5'd8;
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd7, 32'h7); tick();
    set_in(1'b1, 5'd4, 32'h4, 1'b1, 5'd8, 32'h8); tick();
    set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_total++;
    if (bus.lsu_ready_o !== 1'b0) begin n_bad++; $display("FAIL mid_full: got %b want 0", bus.lsu_ready_o); end
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.rf_we_o, bus.lsu_ready_o, bus.hazard_a_o, bus.hazard_b_o} !== 4'b0100) begin
      n_bad++; $display("FAIL mid_reset: got we/ready/ha/hb=%b%b%b%b want 0100",
                        bus.rf_we_o, bus.lsu_ready_o, bus.hazard_a_o, bus.hazard_b_o);
    end
    mq.delete(); exp_q.delete(); m_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++;
      if (bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL post_reset_we: got %b want 0", bus.rf_we_o); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      bus.raddr_a_i = 5'($urandom_range(0, 7));
      bus.raddr_b_i = 5'($urandom_range(0, 7));
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_ex_write();
    test_lsu_order();
    test_fifo_full();
    test_waw();
    test_same_cycle();
    test_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
